clk_div_ctrl: RTL
=================

# clk_div_ctrl

Programmable clock-divider controller that sequences a derived clock from the system clock `clk`. It generates a glitch-free divided output `clk_out` with a companion one-cycle `tick` strobe. Run/stop is gated by `en`, and the divisor is changed on the fly through a request/acknowledge handshake, applied only at period boundaries. It sits between the free-running clock source and any slower-rate logic or testbench stimulus that needs a controllable derived clock.

## Interface
- `CNT_W`, default 8: width of the divisor and of the internal half-period counter.

- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: level; 1 = run divided clock, 0 = stop it cleanly (low).
- `div_req` input 1: divisor change request; internally rising-edge detected.
- `div_val` input CNT_W: new divisor N; held stable from `div_req` rise until `div_ack`.
- `div_ack` output 1: one-cycle pulse in the cycle `div_cur` takes the new value.
- `div_cur` output CNT_W: divisor in use.
- `clk_out` output 1: divided clock; each phase lasts N+1 `clk` cycles.
- `tick` output 1: one-cycle pulse coincident with each 0->1 transition of `clk_out`.
- `busy` output 1: high when state != STOPPED or a divisor request is pending.

## Operation
- All outputs are registered. Reset values: `clk_out`=0, `tick`=0, `div_ack`=0, `div_cur`=0, `busy`=0, counter=0, pending=0, state=STOPPED.
- Half-period counter `cnt` runs 0..N, with N=`div_cur`. When `cnt==N`: toggle `clk_out` and set `cnt` to 0; otherwise increment `cnt`. This gives high N+1, low N+1, and a period of 2(N+1) cycles. N=0 gives clk/2.
- States:
  - STOPPED: `clk_out`=0, `cnt`=0. If `en`=1, go to RUN.
  - RUN: counts and toggles. If `en`=0 and `clk_out`=0, go to STOPPED with `cnt` cleared. If `en`=0 and `clk_out`=1, go to STOPPING.
  - STOPPING: keeps counting. At the 1->0 toggle, go to STOPPED. If `en` returns to 1 before then, go to RUN; `cnt` and `clk_out` are undisturbed.
- Divisor handshake:
  - A `div_req` rising edge sets `pending` and latches `div_val` into a shadow register. Holding `div_req` high creates no further requests.
  - In STOPPED, a pending value is applied on the next edge, with `div_ack`=1 in that cycle.
  - In RUN or STOPPING, the value is applied at the next 1->0 toggle of `clk_out`. `cnt` restarts at 0 with the new N, and `div_ack` pulses in the same cycle.
  - A new `div_req` rise while `pending`=1 overwrites the shadow value; only one `div_ack` is issued.
- Simultaneous events:
  - `en` falls on the same edge as a 1->0 toggle: STOPPED, no extra phase.
  - Divisor apply and stop on the same toggle: the new `div_cur` is applied, `div_ack` pulses, then STOPPED.
  - `div_req` rise on the same edge as an apply: the pending value is applied, and the new request becomes pending.
- Reset asserted at any time forces all reset values asynchronously. A pending request is discarded and no `div_ack` is issued.

## Timing
- `en` sampled high at edge t in STOPPED: RUN from t. The first `clk_out` rise and `tick` occur at edge t+N+1.
- `tick` is high exactly one cycle per period, in the first high cycle of `clk_out`.
- `clk_out` never produces a high phase shorter than N+1 cycles, and never a low phase shorter than N+1 cycles while running.
- `div_ack` latency:
  - STOPPED: 1 cycle after the request edge.
  - Running: 0..2(N+1) cycles, up to the next falling toggle.
- `busy` updates on the same edge as the state or `pending` change.

## Test plan
- Reset, then `en`=1 with `div_cur`=0 -> `clk_out` toggles every cycle (period 2); `tick` every 2 cycles starting 1 cycle after `en`.
- While stopped, request N=3 -> `div_ack` 1 cycle later and `div_cur`=3. Then `en`=1 -> `clk_out` high 4 and low 4; `tick` every 8 cycles.
- Running N=3, request N=1 during the 2nd high cycle -> remaining high cycles complete. `div_ack` and `div_cur`=1 at the falling toggle; then low 2 and high 2.
- Running N=3, drop `en` in the 1st high cycle -> high lasts 4 cycles total, then `clk_out`=0 and `busy`=0. Re-raising `en` in STOPPING -> no disturbance to the phase.
- Drop `en` and request N=5 so that both land on the same falling toggle -> a single `div_ack`, `div_cur`=5, STOPPED.
- Assert `rst_n`=0 mid-high phase with a request pending -> all outputs 0 immediately; after release, `div_ack` never pulses.

Source files
------------

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_ctrl
//  Purpose  : Programmable clock divider. Produces a glitch-free divided clock
//             clk_out (each phase N+1 clk cycles, N = div_cur) with a one-cycle
//             tick on every rising edge of clk_out. en starts/stops the output
//             cleanly (a started high phase always completes). The divisor is
//             changed through a req/ack handshake and only takes effect at a
//             falling boundary of clk_out (or immediately while stopped).
//  Ports    : clk      - system clock
//             rst_n    - asynchronous active-low reset
//             en       - run (1) / stop low (0)
//             div_req  - divisor change request (rising-edge detected)
//             div_val  - requested divisor, stable until div_ack
//             div_ack  - one-cycle pulse when div_cur takes the new value
//             div_cur  - divisor in use
//             clk_out  - divided clock
//             tick     - one-cycle pulse with each 0->1 of clk_out
//             busy     - not stopped, or a divisor request pending
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             div_req,
   input  logic [CNT_W-1:0] div_val,
   output logic             div_ack,
   output logic [CNT_W-1:0] div_cur,
   output logic             clk_out,
   output logic             tick,
   output logic             busy
);

   localparam logic [1:0] c_stopped  = 2'd0;
   localparam logic [1:0] c_run      = 2'd1;
   localparam logic [1:0] c_stopping = 2'd2;

   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_shadow;
   logic [CNT_W-1:0] w_shadow_nxt;
   logic [CNT_W-1:0] w_cur_nxt;
   logic             r_pending;
   logic             w_pending_nxt;
   logic             r_req_d;
   logic             w_clk_nxt;
   logic             w_tick_nxt;
   logic             w_ack_nxt;
   logic             w_busy_nxt;
   logic             w_req_rise;
   logic             w_at_end;
   logic             w_fall;
   logic             w_apply;

   assign w_req_rise = div_req & ~r_req_d;
   // Last cycle of the current phase: the counter has reached N.
   assign w_at_end   = (r_state != c_stopped) && (r_cnt == div_cur);
   assign w_fall     = w_at_end & clk_out;
   // A pending divisor lands immediately when stopped, otherwise only at a
   // falling boundary so no phase is ever shortened.
   assign w_apply    = r_pending & ((r_state == c_stopped) | w_fall);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_stopped;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_stopped: begin
            if (en) w_state_nxt = c_run;
         end
         c_run: begin
            // A low phase may be cut short; a high phase must finish first.
            if (!en) begin
               if (!clk_out || w_fall) w_state_nxt = c_stopped;
               else                    w_state_nxt = c_stopping;
            end
         end
         c_stopping: begin
            if (en)          w_state_nxt = c_run;
            else if (w_fall) w_state_nxt = c_stopped;
         end
         default: w_state_nxt = c_stopped;
      endcase
   end

   // ------------------------------------------------------ output next values
   always_comb begin
      w_cnt_nxt  = '0;
      w_clk_nxt  = 1'b0;
      w_tick_nxt = 1'b0;
      // Counting only happens while running now and next; entering or leaving
      // STOPPED leaves the counter cleared and the output low.
      if ((r_state != c_stopped) && (w_state_nxt != c_stopped)) begin
         if (w_at_end) begin
            w_clk_nxt  = ~clk_out;
            w_tick_nxt = ~clk_out;
         end else begin
            w_cnt_nxt  = r_cnt + c_cnt_one;
            w_clk_nxt  = clk_out;
         end
      end

      w_ack_nxt    = w_apply;
      w_cur_nxt    = w_apply ? r_shadow : div_cur;
      // A request arriving on the apply edge becomes the next pending value.
      w_shadow_nxt = w_req_rise ? div_val : r_shadow;
      if (w_req_rise)   w_pending_nxt = 1'b1;
      else if (w_apply) w_pending_nxt = 1'b0;
      else              w_pending_nxt = r_pending;

      w_busy_nxt = (w_state_nxt != c_stopped) | w_pending_nxt;
   end

   // ------------------------------------------------------------ datapath regs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_shadow  <= '0;
         r_pending <= 1'b0;
         r_req_d   <= 1'b0;
         clk_out   <= 1'b0;
         tick      <= 1'b0;
         div_ack   <= 1'b0;
         div_cur   <= '0;
         busy      <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_shadow  <= w_shadow_nxt;
         r_pending <= w_pending_nxt;
         r_req_d   <= div_req;
         clk_out   <= w_clk_nxt;
         tick      <= w_tick_nxt;
         div_ack   <= w_ack_nxt;
         div_cur   <= w_cur_nxt;
         busy      <= w_busy_nxt;
      end
   end

endmodule
`default_nettype wire
